sb_msg_responder: RTL and testbench

//  Partner-side sideband (SB) responder for link training.
//  - Pulls decoded 64-bit SB request messages from SB_RX using the req/valid handshake.
//  - Checks each request against the current LTSM state and builds the matching response.
//  - Hands the response to SB_TX using the valid/ack handshake.
//  - Sits beside the LTSM sub-state blocks and answers the remote die's training requests.

---
 rtl/sb_msg_responder.sv | 130 +++++++++++++
 tb/tb_sb_msg_responder.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sb_msg_responder.sv
// Sideband training-request responder: pulls a request from SB_RX and validates it
// against the LTSM state. A legal request gets a response handed to SB_TX.
module sb_msg_responder #(
  parameter logic [7:0]  REQ_CODE    = 8'h85,
  parameter logic [7:0]  RSP_CODE    = 8'h8A,
  parameter int unsigned ACK_TIMEOUT = 1000
) (
  input  logic        clk_100MHz,
  input  logic        reset_n,
  input  logic        enable_i,
  input  logic [2:0]  ltsm_state_i,
  input  logic [63:0] rx_msg_i,
  input  logic        rx_msg_valid_i,
  output logic        rx_msg_req_o,
  input  logic [31:0] resp_data_i,
  output logic [63:0] tx_msg_o,
  output logic        tx_msg_valid_o,
  input  logic        tx_msg_ack_i,
  output logic        busy_o,
  output logic        err_o,
  output logic [7:0]  rsp_count_o
);

  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, REQ, DECODE, SEND} state_e;

  state_e           state_q, state_d;
  logic [31:0]      rx_msg_q, rx_msg_d;
  logic [63:0]      tx_msg_q, tx_msg_d;
  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             err_q, err_d;
  logic [7:0]       rsp_count_q, rsp_count_d;

  logic             ltsm_ok;
  logic             sub_ok;
  logic             req_legal;
  logic             tmo_hit;
  logic [7:0]       sub;
  logic             unused_rx_data;

  // The remote request's data word carries nothing the response needs.
  assign unused_rx_data = ^rx_msg_i[63:32];

  assign sub     = rx_msg_q[15:8];
  assign ltsm_ok = (ltsm_state_i >= 3'd1) && (ltsm_state_i <= 3'd4);
  assign tmo_hit = (tmo_cnt_q == CNT_W'(ACK_TIMEOUT - 1));

  always_comb begin
    sub_ok = 1'b0;
    case (ltsm_state_i)
      3'd1:    sub_ok = (sub == 8'h01);
      3'd2:    sub_ok = (sub >= 8'h02) && (sub <= 8'h0F);
      3'd3:    sub_ok = (sub >= 8'h10) && (sub <= 8'h1F);
      3'd4:    sub_ok = (sub == 8'h20);
      default: sub_ok = 1'b0;
    endcase
    req_legal = (rx_msg_q[7:0] == REQ_CODE) && sub_ok;
  end

  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      rx_msg_q    <= '0;
      tx_msg_q    <= '0;
      tmo_cnt_q   <= '0;
      err_q       <= 1'b0;
      rsp_count_q <= '0;
    end else begin
      state_q     <= state_d;
      rx_msg_q    <= rx_msg_d;
      tx_msg_q    <= tx_msg_d;
      tmo_cnt_q   <= tmo_cnt_d;
      err_q       <= err_d;
      rsp_count_q <= rsp_count_d;
    end
  end

  // Dropping enable returns to IDLE from anywhere without flagging an error.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable_i && ltsm_ok) state_d = REQ;
      REQ:     if (!enable_i) state_d = IDLE;
               else if (rx_msg_valid_i) state_d = DECODE;
      DECODE:  if (!enable_i || !req_legal) state_d = IDLE;
               else state_d = SEND;
      SEND:    if (!enable_i || tx_msg_ack_i || tmo_hit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rx_msg_d    = rx_msg_q;
    tx_msg_d    = tx_msg_q;
    tmo_cnt_d   = '0;
    err_d       = 1'b0;
    rsp_count_d = rsp_count_q;
    case (state_q)
      REQ: begin
        if (enable_i && rx_msg_valid_i) rx_msg_d = rx_msg_i[31:0];
      end
      DECODE: begin
        if (enable_i) begin
          if (req_legal) tx_msg_d = {resp_data_i, rx_msg_q[31:16], sub, RSP_CODE};
          else           err_d    = 1'b1;
        end
      end
      SEND: begin
        // An ack on the last timeout cycle still counts as a clean response.
        if (enable_i) begin
          if (tx_msg_ack_i)  rsp_count_d = rsp_count_q + 8'd1;
          else if (tmo_hit)  err_d       = 1'b1;
          else               tmo_cnt_d   = tmo_cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    rx_msg_req_o   = (state_q == REQ);
    tx_msg_valid_o = (state_q == SEND);
    busy_o         = (state_q != IDLE);
    tx_msg_o       = tx_msg_q;
    err_o          = err_q;
    rsp_count_o    = rsp_count_q;
  end

endmodule

// File: tb/tb_sb_msg_responder.sv
// Directed bench for sb_msg_responder: legal and illegal requests, ack timeout,
// enable abort, spurious strobes, count wrap and asynchronous reset.
module tb_sb_msg_responder;

  logic        clk_100MHz = 1'b0;
  logic        reset_n;
  logic        enable_i;
  logic [2:0]  ltsm_state_i;
  logic [63:0] rx_msg_i;
  logic        rx_msg_valid_i;
  logic        rx_msg_req_o;
  logic [31:0] resp_data_i;
  logic [63:0] tx_msg_o;
  logic        tx_msg_valid_o;
  logic        tx_msg_ack_i;
  logic        busy_o;
  logic        err_o;
  logic [7:0]  rsp_count_o;

  int          pass_cnt = 0;
  int          total_cnt = 0;
  logic [7:0]  exp_count = 8'd0;

  always #5 clk_100MHz = ~clk_100MHz;

  sb_msg_responder dut (
    .clk_100MHz    (clk_100MHz),
    .reset_n       (reset_n),
    .enable_i      (enable_i),
    .ltsm_state_i  (ltsm_state_i),
    .rx_msg_i      (rx_msg_i),
    .rx_msg_valid_i(rx_msg_valid_i),
    .rx_msg_req_o  (rx_msg_req_o),
    .resp_data_i   (resp_data_i),
    .tx_msg_o      (tx_msg_o),
    .tx_msg_valid_o(tx_msg_valid_o),
    .tx_msg_ack_i  (tx_msg_ack_i),
    .busy_o        (busy_o),
    .err_o         (err_o),
    .rsp_count_o   (rsp_count_o)
  );

  task automatic tick();
    @(posedge clk_100MHz);
    #1;
  endtask

  // From IDLE: enable and move into REQ.
  task automatic start_req(input logic [2:0] st);
    enable_i     = 1'b1;
    ltsm_state_i = st;
    tick();
  endtask

  // From REQ: present one message; returns with the DUT in DECODE.
  task automatic deliver(input logic [63:0] msg);
    rx_msg_i       = msg;
    rx_msg_valid_i = 1'b1;
    tick();
    rx_msg_valid_i = 1'b0;
    rx_msg_i       = '0;
  endtask

  task automatic go_idle();
    enable_i = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0; enable_i = 1'b0; ltsm_state_i = 3'd0; rx_msg_i = '0;
    rx_msg_valid_i = 1'b0; resp_data_i = '0; tx_msg_ack_i = 1'b0;
    tick(); tick();
    total_cnt++;
    if ({rx_msg_req_o, tx_msg_valid_o, busy_o, err_o} !== 4'b0000 || tx_msg_o !== 64'h0 || rsp_count_o !== 8'h0)
      $display("FAIL reset: req=%b valid=%b busy=%b err=%b tx=%h cnt=%0d expected all zero",
               rx_msg_req_o, tx_msg_valid_o, busy_o, err_o, tx_msg_o, rsp_count_o);
    else pass_cnt++;
    reset_n = 1'b1;
    tick();
    $display("reset: outputs idle after reset");
  endtask

  task automatic test_basic();
    start_req(3'd1);
    total_cnt++;
    if (rx_msg_req_o !== 1'b1 || busy_o !== 1'b1)
      $display("FAIL basic_req: req=%b busy=%b expected 1 1", rx_msg_req_o, busy_o);
    else pass_cnt++;
    deliver(64'h00000000_0000_01_85);
    resp_data_i = 32'hCAFE0001;
    total_cnt++;
    if (rx_msg_req_o !== 1'b0 || tx_msg_valid_o !== 1'b0)
      $display("FAIL basic_decode: req=%b valid=%b expected 0 0", rx_msg_req_o, tx_msg_valid_o);
    else pass_cnt++;
    tick();
    resp_data_i = 32'hDEAD_BEEF;
    total_cnt++;
    if (tx_msg_valid_o !== 1'b1 || tx_msg_o !== 64'hCAFE0001_0000_01_8A)
      $display("FAIL basic_send: valid=%b tx=%h expected 1 cafe00010000018a", tx_msg_valid_o, tx_msg_o);
    else pass_cnt++;
    tick(); tick();
    total_cnt++;
    if (tx_msg_valid_o !== 1'b1 || tx_msg_o !== 64'hCAFE0001_0000_01_8A)
      $display("FAIL basic_hold: valid=%b tx=%h expected 1 cafe00010000018a", tx_msg_valid_o, tx_msg_o);
    else pass_cnt++;
    tx_msg_ack_i = 1'b1;
    tick();
    tx_msg_ack_i = 1'b0;
    exp_count++;
    total_cnt++;
    if (tx_msg_valid_o !== 1'b0 || rsp_count_o !== exp_count || err_o !== 1'b0)
      $display("FAIL basic_ack: valid=%b cnt=%0d err=%b expected 0 %0d 0", tx_msg_valid_o, rsp_count_o, err_o, exp_count);
    else pass_cnt++;
    go_idle();
    $display("basic: SBINIT response tx=cafe00010000018a count=%0d", rsp_count_o);
  endtask

  task automatic test_legal_table();
    logic [2:0]  st  [4] = '{3'd2, 3'd3, 3'd3, 3'd4};
    logic [7:0]  sb  [4] = '{8'h0F, 8'h10, 8'h1F, 8'h20};
    logic [31:0] rd  [4] = '{32'h11112222, 32'h33334444, 32'h55556666, 32'h77778888};
    logic [63:0] exp_msg;
    for (int i = 0; i < 4; i++) begin
      start_req(st[i]);
      deliver({32'hFFFF_FFFF, 8'hA5, 8'(i), sb[i], 8'h85});
      resp_data_i = rd[i];
      tick();
      exp_msg = {rd[i], 8'hA5, 8'(i), sb[i], 8'h8A};
      total_cnt++;
      if (tx_msg_valid_o !== 1'b1 || tx_msg_o !== exp_msg)
        $display("FAIL legal_%0d: valid=%b tx=%h expected 1 %h", i, tx_msg_valid_o, tx_msg_o, exp_msg);
      else pass_cnt++;
      tx_msg_ack_i = 1'b1;
      tick();
      tx_msg_ack_i = 1'b0;
      exp_count++;
      total_cnt++;
      if (rsp_count_o !== exp_count || err_o !== 1'b0)
        $display("FAIL legal_cnt_%0d: cnt=%0d err=%b expected %0d 0", i, rsp_count_o, err_o, exp_count);
      else pass_cnt++;
      go_idle();
      $display("legal: state=%0d sub=%h tx=%h", st[i], sb[i], exp_msg);
    end
  endtask

  task automatic test_illegal();
    logic [2:0] st [5] = '{3'd3, 3'd2, 3'd1, 3'd1, 3'd4};
    logic [7:0] sb [5] = '{8'h05, 8'h10, 8'h02, 8'h01, 8'h21};
    logic [7:0] cd [5] = '{8'h85, 8'h85, 8'h85, 8'h84, 8'h85};
    logic       seen_valid;
    for (int i = 0; i < 5; i++) begin
      start_req(st[i]);
      deliver({32'h0, 16'h0, sb[i], cd[i]});
      seen_valid = tx_msg_valid_o;
      total_cnt++;
      if (err_o !== 1'b0)
        $display("FAIL illegal_early_%0d: err=%b expected 0", i, err_o);
      else pass_cnt++;
      tick();
      seen_valid |= tx_msg_valid_o;
      total_cnt++;
      if (err_o !== 1'b1 || busy_o !== 1'b0)
        $display("FAIL illegal_err_%0d: err=%b busy=%b expected 1 0", i, err_o, busy_o);
      else pass_cnt++;
      go_idle();
      seen_valid |= tx_msg_valid_o;
      total_cnt++;
      if (err_o !== 1'b0 || seen_valid !== 1'b0 || rsp_count_o !== exp_count)
        $display("FAIL illegal_after_%0d: err=%b valid_seen=%b cnt=%0d expected 0 0 %0d",
                 i, err_o, seen_valid, rsp_count_o, exp_count);
      else pass_cnt++;
      $display("illegal: state=%0d code=%h sub=%h rejected", st[i], cd[i], sb[i]);
    end
  endtask

  task automatic test_timeout();
    int n = 0;
    start_req(3'd2);
    deliver({32'h0, 16'hBEEF, 8'h02, 8'h85});
    resp_data_i = 32'h12345678;
    tick();
    total_cnt++;
    if (tx_msg_o !== 64'h12345678_BEEF_02_8A)
      $display("FAIL timeout_msg: tx=%h expected 12345678beef028a", tx_msg_o);
    else pass_cnt++;
    while (tx_msg_valid_o === 1'b1 && n < 2000) begin
      n++;
      tick();
    end
    total_cnt++;
    if (n !== 1000)
      $display("FAIL timeout_len: valid cycles=%0d expected 1000", n);
    else pass_cnt++;
    total_cnt++;
    if (err_o !== 1'b1 || rsp_count_o !== exp_count)
      $display("FAIL timeout_err: err=%b cnt=%0d expected 1 %0d", err_o, rsp_count_o, exp_count);
    else pass_cnt++;
    go_idle();
    total_cnt++;
    if (err_o !== 1'b0)
      $display("FAIL timeout_pulse: err=%b expected 0", err_o);
    else pass_cnt++;
    $display("timeout: valid held %0d cycles then error", n);
  endtask

  task automatic test_ack_on_last();
    start_req(3'd2);
    deliver({32'h0, 16'h0, 8'h03, 8'h85});
    tick();
    for (int i = 0; i < 999; i++) tick();
    total_cnt++;
    if (tx_msg_valid_o !== 1'b1)
      $display("FAIL lastack_valid: valid=%b expected 1", tx_msg_valid_o);
    else pass_cnt++;
    tx_msg_ack_i = 1'b1;
    tick();
    tx_msg_ack_i = 1'b0;
    exp_count++;
    total_cnt++;
    if (err_o !== 1'b0 || tx_msg_valid_o !== 1'b0 || rsp_count_o !== exp_count)
      $display("FAIL lastack: err=%b valid=%b cnt=%0d expected 0 0 %0d", err_o, tx_msg_valid_o, rsp_count_o, exp_count);
    else pass_cnt++;
    go_idle();
    $display("ack_on_last: count=%0d no error", rsp_count_o);
  endtask

  task automatic test_enable_abort();
    start_req(3'd1);
    enable_i       = 1'b0;
    rx_msg_i       = 64'h0000_0001_85;
    rx_msg_valid_i = 1'b1;
    tick();
    rx_msg_valid_i = 1'b0;
    total_cnt++;
    if (rx_msg_req_o !== 1'b0 || busy_o !== 1'b0 || err_o !== 1'b0)
      $display("FAIL abort_req: req=%b busy=%b err=%b expected 0 0 0", rx_msg_req_o, busy_o, err_o);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (busy_o !== 1'b0 || err_o !== 1'b0)
      $display("FAIL abort_req_discard: busy=%b err=%b expected 0 0", busy_o, err_o);
    else pass_cnt++;
    start_req(3'd1);
    deliver(64'h0000_0001_85);
    tick();
    total_cnt++;
    if (tx_msg_valid_o !== 1'b1)
      $display("FAIL abort_send_pre: valid=%b expected 1", tx_msg_valid_o);
    else pass_cnt++;
    enable_i = 1'b0;
    tick();
    total_cnt++;
    if (tx_msg_valid_o !== 1'b0 || busy_o !== 1'b0 || err_o !== 1'b0 || rsp_count_o !== exp_count)
      $display("FAIL abort_send: valid=%b busy=%b err=%b cnt=%0d expected 0 0 0 %0d",
               tx_msg_valid_o, busy_o, err_o, rsp_count_o, exp_count);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (err_o !== 1'b0)
      $display("FAIL abort_send_err: err=%b expected 0", err_o);
    else pass_cnt++;
    $display("enable_abort: REQ and SEND aborted cleanly");
  endtask

  task automatic test_spurious();
    enable_i       = 1'b0;
    tx_msg_ack_i   = 1'b1;
    rx_msg_valid_i = 1'b1;
    rx_msg_i       = 64'h0000_0001_85;
    tick();
    tx_msg_ack_i   = 1'b0;
    rx_msg_valid_i = 1'b0;
    tick();
    total_cnt++;
    if (rsp_count_o !== exp_count || busy_o !== 1'b0 || err_o !== 1'b0)
      $display("FAIL spurious: cnt=%0d busy=%b err=%b expected %0d 0 0", rsp_count_o, busy_o, err_o, exp_count);
    else pass_cnt++;
    $display("spurious: strobes in IDLE ignored");
  endtask

  task automatic test_back_to_back();
    int n = 256 - int'(exp_count);
    for (int i = 0; i < n; i++) begin
      start_req(3'd4);
      deliver({32'h0, 16'h0, 8'h20, 8'h85});
      tick();
      tx_msg_ack_i = 1'b1;
      tick();
      tx_msg_ack_i = 1'b0;
      exp_count++;
      if (i == n - 2) begin
        total_cnt++;
        if (rsp_count_o !== 8'd255)
          $display("FAIL wrap_255: cnt=%0d expected 255", rsp_count_o);
        else pass_cnt++;
      end
    end
    total_cnt++;
    if (rsp_count_o !== 8'd0)
      $display("FAIL wrap_0: cnt=%0d expected 0", rsp_count_o);
    else pass_cnt++;
    go_idle();
    $display("back_to_back: %0d responses, count wrapped to %0d", n, rsp_count_o);
  endtask

  task automatic test_async_reset();
    start_req(3'd1);
    deliver(64'h0000_0001_85);
    resp_data_i = 32'hABCD0123;
    tick();
    tx_msg_ack_i = 1'b1;
    tick();
    tx_msg_ack_i = 1'b0;
    start_req(3'd1);
    deliver(64'h0000_0001_85);
    tick();
    total_cnt++;
    if (tx_msg_valid_o !== 1'b1 || rsp_count_o !== 8'd1)
      $display("FAIL areset_pre: valid=%b cnt=%0d expected 1 1", tx_msg_valid_o, rsp_count_o);
    else pass_cnt++;
    #2;
    reset_n = 1'b0;
    #1;
    total_cnt++;
    if ({rx_msg_req_o, tx_msg_valid_o, busy_o, err_o} !== 4'b0000 || tx_msg_o !== 64'h0 || rsp_count_o !== 8'h0)
      $display("FAIL areset: req=%b valid=%b busy=%b err=%b tx=%h cnt=%0d expected all zero",
               rx_msg_req_o, tx_msg_valid_o, busy_o, err_o, tx_msg_o, rsp_count_o);
    else pass_cnt++;
    enable_i = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    total_cnt++;
    if (err_o !== 1'b0 || busy_o !== 1'b0)
      $display("FAIL areset_after: err=%b busy=%b expected 0 0", err_o, busy_o);
    else pass_cnt++;
    $display("async_reset: outputs cleared during SEND");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_legal_table();
    test_illegal();
    test_timeout();
    test_ack_on_last();
    test_enable_abort();
    test_spurious();
    test_back_to_back();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
